// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, widths and write-scheduler state encoding.
// Also imported by the VGA read-address logic.
package fb_pkg;

    localparam int unsigned DISPLAY_X  = 320;
    localparam int unsigned DISPLAY_Y  = 240;
    localparam int unsigned FRAME      = DISPLAY_X * DISPLAY_Y;
    localparam int unsigned BANK1_BASE = FRAME;
    localparam int unsigned PIX_W      = 12;
    localparam int unsigned ADDR_W     = 18;
    localparam int unsigned IDX_W      = 17;

    typedef enum logic [1:0] {IDLE, FILL, WAIT_SWAP} fb_state_e;

    // Base address of a bank for a given frame size (bank 1 sits right after bank 0).
    function automatic logic [ADDR_W-1:0] bank_base(input logic bank, input int unsigned frame);
        return bank ? ADDR_W'(frame) : '0;
    endfunction

endpackage

// File: rtl/fb_write_scheduler_if.sv
// Pixel-stream, fill-control, vblank and BRAM write-port bundle of the write scheduler.
// master drives the sources, slave is the scheduler.
interface fb_write_scheduler_if;
    import fb_pkg::*;

    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_ready;
    logic              fill_start;
    logic [PIX_W-1:0]  fill_color;
    logic              vblank;
    logic              bram_wea;
    logic [ADDR_W-1:0] bram_addr;
    logic [PIX_W-1:0]  bram_din;
    logic              disp_bank;
    logic              fill_busy;
    logic              frame_done;
    logic [7:0]        frame_count;

    modport master (
        output pix_valid, pix_data, fill_start, fill_color, vblank,
        input  pix_ready, bram_wea, bram_addr, bram_din, disp_bank, fill_busy, frame_done,
               frame_count
    );

    modport slave (
        input  pix_valid, pix_data, fill_start, fill_color, vblank,
        output pix_ready, bram_wea, bram_addr, bram_din, disp_bank, fill_busy, frame_done,
               frame_count
    );

endinterface

// File: rtl/fb_index_counter.sv
// Frame-modulo pixel index shared by the stream and fill paths.
// Wraps to 0 only through the explicit last-index compare.
module fb_index_counter
    import fb_pkg::*;
#(
    parameter int unsigned Frame = FRAME
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o
);

    logic [IDX_W-1:0] idx_q;

    assign last_o = (idx_q == IDX_W'(Frame - 1));
    assign idx_o  = idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
        end else if (clear_i) begin
            idx_q <= '0;
        end else if (inc_i) begin
            idx_q <= last_o ? '0 : idx_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Sequences UART pixels and full-frame fills into the back bank of the frame buffer
// and swaps front/back banks during vertical blanking.
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int unsigned DisplayX = DISPLAY_X,
    parameter int unsigned DisplayY = DISPLAY_Y
) (
    input logic                 clk,
    input logic                 reset,
    fb_write_scheduler_if.slave bus
);

    localparam int unsigned Frame = DisplayX * DisplayY;

    fb_state_e         state_q;
    logic [PIX_W-1:0]  fill_color_q;
    logic              disp_bank_q;
    logic              wea_q;
    logic [ADDR_W-1:0] addr_q;
    logic [PIX_W-1:0]  din_q;
    logic              fill_busy_q;
    logic              frame_done_q;
    logic [7:0]        frame_count_q;

    logic [IDX_W-1:0]  idx;
    logic              idx_last;
    logic              idx_inc;
    logic              idx_clear;
    logic              pix_ready;
    logic              accept;
    logic [ADDR_W-1:0] wr_addr;

    always_comb begin
        pix_ready = (state_q == IDLE) && !bus.fill_start;
        accept    = pix_ready && bus.pix_valid;
        idx_clear = (state_q == IDLE) && bus.fill_start;
        idx_inc   = accept || (state_q == FILL);
        wr_addr   = bank_base(~disp_bank_q, Frame) + ADDR_W'(idx);
    end

    fb_index_counter #(
        .Frame (Frame)
    ) u_index_counter (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (idx_inc),
        .clear_i (idx_clear),
        .idx_o   (idx),
        .last_o  (idx_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            fill_color_q  <= '0;
            disp_bank_q   <= 1'b0;
            wea_q         <= 1'b0;
            addr_q        <= '0;
            din_q         <= '0;
            fill_busy_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            wea_q        <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.fill_start) begin
                        // Any partly streamed frame is dropped; the counter restarts at 0.
                        fill_color_q <= bus.fill_color;
                        fill_busy_q  <= 1'b1;
                        state_q      <= FILL;
                    end else if (accept) begin
                        wea_q  <= 1'b1;
                        addr_q <= wr_addr;
                        din_q  <= bus.pix_data;
                        if (idx_last) begin
                            state_q <= WAIT_SWAP;
                        end
                    end
                end
                FILL: begin
                    wea_q  <= 1'b1;
                    addr_q <= wr_addr;
                    din_q  <= fill_color_q;
                    if (idx_last) begin
                        fill_busy_q <= 1'b0;
                        state_q     <= WAIT_SWAP;
                    end
                end
                WAIT_SWAP: begin
                    // The final write was registered on entry, so it lands before the toggle.
                    if (bus.vblank) begin
                        disp_bank_q   <= ~disp_bank_q;
                        frame_done_q  <= 1'b1;
                        frame_count_q <= frame_count_q + 8'd1;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pix_ready   = pix_ready;
    assign bus.bram_wea    = wea_q;
    assign bus.bram_addr   = addr_q;
    assign bus.bram_din    = din_q;
    assign bus.disp_bank   = disp_bank_q;
    assign bus.fill_busy   = fill_busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_count = frame_count_q;

endmodule
